am_lock_rx_core: RTL and testbench

AM_LOCK_RX_CORE -- requirements
Module: am_lock_rx

---
 rtl/am_lock_rx_core_if.sv | 22 ++
 rtl/am_lock_rx_core.sv | 142 ++++++++++++++
 tb/tb_am_lock_rx_core.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/am_lock_rx_core_if.sv
// Receive-side bundle for the alignment-marker lock core: incoming block
// stream plus lock/slip status returned to the upstream gearbox.
interface am_lock_rx_core_if #(
   parameter int unsigned BLOCK_W = 66,
   parameter int unsigned LANE_N  = 4
);
   logic               valid_i;
   logic [BLOCK_W-1:0] block_i;
   logic               slip_v_o;
   logic               lock_v_o;
   logic [LANE_N-1:0]  lane_o;

   modport master (
      output valid_i, block_i,
      input  slip_v_o, lock_v_o, lane_o
   );

   modport slave (
      input  valid_i, block_i,
      output slip_v_o, lock_v_o, lane_o
   );
endinterface

// File: rtl/am_lock_rx_core.sv
// Alignment-marker lock FSM: finds a lane marker, confirms it one gap later,
// then tracks markers while locked and requests a slip after 4 misses.
module am_lock_rx_core #(
   parameter int unsigned BLOCK_W = 66,
   parameter int unsigned LANE_N  = 4,
   parameter int unsigned GAP_N   = 16383
) (
   input logic               clk,
   input logic               nreset,
   am_lock_rx_core_if.slave  am_io
);

   localparam int unsigned CNT_W = $clog2(GAP_N + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GAP_N - 1);

   typedef enum logic [2:0] {
      FIND_1ST,
      COUNT_1,
      COMP_2ND,
      LOCKED_COUNT,
      COMP_AM,
      SLIP
   } state_t;

   state_t              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [1:0]          inv_q;
   logic [LANE_N-1:0]   lane_sel_q;
   logic                slip_v_q;
   logic                lock_v_q;
   logic [LANE_N-1:0]   lane_q;

   logic [LANE_N-1:0]   hit;
   logic                hdr_ok;
   logic [47:0]         key;
   logic                match_sel;
   logic                bip_unused;

   // Pattern packed as {M6,M5,M4,M2,M1,M0}; lanes beyond 3 have no marker.
   function automatic logic [47:0] lane_pat(input int unsigned idx);
      case (idx)
         0:       return 48'hB8896F_477690;
         1:       return 48'h193B0F_E6C4F0;
         2:       return 48'h649A3A_9B65C5;
         3:       return 48'hC2865D_3D79A2;
         default: return '0;
      endcase
   endfunction

   always_comb begin
      hdr_ok = (am_io.block_i[BLOCK_W-1 -: 2] == 2'b10);
      key    = {am_io.block_i[55:32], am_io.block_i[23:0]};
      hit    = '0;
      for (int unsigned l = 0; l < LANE_N; l++) begin
         hit[l] = hdr_ok && (l < 4) && (key == lane_pat(l));
      end
      match_sel = |(hit & lane_sel_q);
   end

   assign bip_unused = ^{am_io.block_i[63:56], am_io.block_i[31:24]};

   always_ff @(posedge clk) begin
      if (nreset) begin
         state_q    <= FIND_1ST;
         cnt_q      <= '0;
         inv_q      <= '0;
         lane_sel_q <= '0;
         slip_v_q   <= 1'b0;
         lock_v_q   <= 1'b0;
         lane_q     <= '0;
      end else begin
         slip_v_q <= 1'b0;
         // Loss of signal drops lock silently; no slip is requested.
         if (!am_io.valid_i && state_q != FIND_1ST) begin
            state_q  <= FIND_1ST;
            cnt_q    <= '0;
            inv_q    <= '0;
            lock_v_q <= 1'b0;
            lane_q   <= '0;
         end else begin
            case (state_q)
               FIND_1ST: begin
                  if (am_io.valid_i && |hit) begin
                     lane_sel_q <= hit;
                     cnt_q      <= '0;
                     state_q    <= COUNT_1;
                  end
               end
               COUNT_1, LOCKED_COUNT: begin
                  if (cnt_q == CNT_LAST) begin
                     cnt_q   <= '0;
                     state_q <= (state_q == COUNT_1) ? COMP_2ND : COMP_AM;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               COMP_2ND: begin
                  cnt_q <= '0;
                  inv_q <= '0;
                  if (match_sel) begin
                     lock_v_q <= 1'b1;
                     lane_q   <= lane_sel_q;
                     state_q  <= LOCKED_COUNT;
                  end else begin
                     slip_v_q <= 1'b1;
                     lock_v_q <= 1'b0;
                     lane_q   <= '0;
                     state_q  <= SLIP;
                  end
               end
               COMP_AM: begin
                  cnt_q <= '0;
                  if (match_sel) begin
                     inv_q   <= '0;
                     state_q <= LOCKED_COUNT;
                  end else if (inv_q == 2'd3) begin
                     inv_q    <= '0;
                     slip_v_q <= 1'b1;
                     lock_v_q <= 1'b0;
                     lane_q   <= '0;
                     state_q  <= SLIP;
                  end else begin
                     inv_q   <= inv_q + 1'b1;
                     state_q <= LOCKED_COUNT;
                  end
               end
               SLIP: begin
                  cnt_q   <= '0;
                  inv_q   <= '0;
                  state_q <= FIND_1ST;
               end
               default: state_q <= FIND_1ST;
            endcase
         end
      end
   end

   assign am_io.slip_v_o = slip_v_q;
   assign am_io.lock_v_o = lock_v_q;
   assign am_io.lane_o   = lane_q;

endmodule

// File: tb/tb_am_lock_rx_core.sv
// Directed bench for am_lock_rx_core using a shortened marker gap.
module tb_am_lock_rx_core;

   localparam int unsigned GAP = 15;

   logic clk = 1'b0;
   logic nreset;
   always #5 clk = ~clk;

   am_lock_rx_core_if #(.BLOCK_W(66), .LANE_N(4)) bus ();

   am_lock_rx_core #(.BLOCK_W(66), .LANE_N(4), .GAP_N(GAP)) dut (
      .clk    (clk),
      .nreset (nreset),
      .am_io  (bus.slave)
   );

   typedef struct {
      bit         vld;
      int         kind;   // 0 filler, 1 marker, 2 payload-corrupt, 3 bad header
      int         lane;
      int         fill;
      bit         e_slip;
      bit         e_lock;
      logic [3:0] e_lane;
   } step_t;

   int n_cmp = 0;
   int n_bad = 0;
   step_t tbl [27];

   function automatic step_t row(bit v, int k, int l, int f, bit s, bit lk, logic [3:0] ln);
      step_t r;
      r.vld = v; r.kind = k; r.lane = l; r.fill = f;
      r.e_slip = s; r.e_lock = lk; r.e_lane = ln;
      return r;
   endfunction

   function automatic logic [65:0] blk(int kind, int lane);
      logic [47:0] p;
      logic [65:0] b;
      case (lane)
         0: p = {8'hB8, 8'h89, 8'h6F, 8'h47, 8'h76, 8'h90};
         1: p = {8'h19, 8'h3B, 8'h0F, 8'hE6, 8'hC4, 8'hF0};
         2: p = {8'h64, 8'h9A, 8'h3A, 8'h9B, 8'h65, 8'hC5};
         default: p = {8'hC2, 8'h86, 8'h5D, 8'h3D, 8'h79, 8'hA2};
      endcase
      if (kind == 0) begin
         b = {2'b01, 32'($urandom), 32'($urandom)};
      end else begin
         b = {2'b10, 8'($urandom), p[47:24], 8'($urandom), p[23:0]};
         if (kind == 2) b[15:8] = b[15:8] ^ 8'h01;
         if (kind == 3) b[65:64] = 2'b11;
      end
      return b;
   endfunction

   task automatic drive(input logic v, input logic [65:0] b);
      bus.valid_i = v;
      bus.block_i = b;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic chk_out(input string nm, input bit s, input bit lk, input logic [3:0] ln);
      chk({nm, ".slip"}, 8'(bus.slip_v_o), 8'(s));
      chk({nm, ".lock"}, 8'(bus.lock_v_o), 8'(lk));
      chk({nm, ".lane"}, 8'(bus.lane_o), 8'(ln));
   endtask

   task automatic fill(input int n, input bit lk);
      for (int f = 0; f < n; f++) begin
         drive(1'b1, blk(0, 0));
         chk("fill.slip", 8'(bus.slip_v_o), 8'h00);
         chk("fill.lock", 8'(bus.lock_v_o), 8'(lk));
      end
   endtask

   initial begin
      tbl[0]  = row(0, 1, 1, GAP,     0, 0, 4'b0000); // ignored: valid low
      tbl[1]  = row(1, 1, 1, GAP - 1, 0, 0, 4'b0000);
      tbl[2]  = row(1, 1, 1, 0,       0, 0, 4'b0000); // one block early
      tbl[3]  = row(1, 0, 0, 0,       1, 0, 4'b0000);
      tbl[4]  = row(1, 0, 0, 0,       0, 0, 4'b0000);
      tbl[5]  = row(1, 1, 2, GAP,     0, 0, 4'b0000);
      tbl[6]  = row(1, 1, 2, GAP,     0, 1, 4'b0100);
      tbl[7]  = row(1, 2, 2, GAP,     0, 1, 4'b0100);
      tbl[8]  = row(1, 3, 2, GAP,     0, 1, 4'b0100);
      tbl[9]  = row(1, 1, 0, GAP,     0, 1, 4'b0100); // other lane = miss
      tbl[10] = row(1, 1, 2, GAP,     0, 1, 4'b0100);
      tbl[11] = row(1, 2, 2, GAP,     0, 1, 4'b0100);
      tbl[12] = row(1, 2, 2, GAP,     0, 1, 4'b0100);
      tbl[13] = row(1, 2, 2, GAP,     0, 1, 4'b0100);
      tbl[14] = row(1, 1, 2, GAP,     0, 1, 4'b0100);
      tbl[15] = row(1, 2, 2, GAP,     0, 1, 4'b0100);
      tbl[16] = row(1, 2, 2, GAP,     0, 1, 4'b0100);
      tbl[17] = row(1, 2, 2, GAP,     0, 1, 4'b0100);
      tbl[18] = row(1, 2, 2, 1,       1, 0, 4'b0000);
      tbl[19] = row(1, 1, 0, GAP,     0, 0, 4'b0000);
      tbl[20] = row(1, 1, 1, 1,       1, 0, 4'b0000);
      tbl[21] = row(1, 1, 3, GAP,     0, 0, 4'b0000);
      tbl[22] = row(1, 1, 3, GAP,     0, 1, 4'b1000);
      tbl[23] = row(1, 2, 3, GAP,     0, 1, 4'b1000);
      tbl[24] = row(1, 2, 3, GAP,     0, 1, 4'b1000);
      tbl[25] = row(1, 3, 3, GAP,     0, 1, 4'b1000);
      tbl[26] = row(1, 2, 3, 1,       1, 0, 4'b0000);

      nreset      = 1'b1;
      bus.valid_i = 1'b1;
      bus.block_i = blk(1, 0);
      repeat (3) @(posedge clk);
      #1;
      chk_out("reset", 0, 0, 4'b0000);
      nreset = 1'b0;

      for (int i = 0; i < 27; i++) begin
         drive(tbl[i].vld, blk(tbl[i].kind, tbl[i].lane));
         chk_out($sformatf("row%0d", i), tbl[i].e_slip, tbl[i].e_lock, tbl[i].e_lane);
         fill(tbl[i].fill, tbl[i].e_lock);
      end

      // Lock on lane0, drop valid for one cycle, then relock.
      drive(1'b1, blk(1, 0));
      fill(GAP, 1'b0);
      drive(1'b1, blk(1, 0));
      chk_out("vlow.lock", 0, 1, 4'b0001);
      fill(5, 1'b1);
      drive(1'b0, blk(0, 0));
      chk_out("vlow.drop", 0, 0, 4'b0000);
      drive(1'b1, blk(0, 0));
      chk_out("vlow.noslip", 0, 0, 4'b0000);
      drive(1'b1, blk(1, 0));
      fill(GAP, 1'b0);
      drive(1'b1, blk(1, 0));
      chk_out("vlow.relock", 0, 1, 4'b0001);

      // Reset while locked, on a cycle carrying a correctly placed marker.
      fill(GAP, 1'b1);
      nreset = 1'b1;
      drive(1'b1, blk(1, 0));
      chk_out("rst.locked", 0, 0, 4'b0000);
      nreset = 1'b0;
      drive(1'b1, blk(1, 0));
      chk_out("rst.first", 0, 0, 4'b0000);
      fill(GAP, 1'b0);
      drive(1'b1, blk(1, 0));
      chk_out("rst.relock", 0, 1, 4'b0001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
